data_ram_responder: RTL

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

---
 rtl/data_ram_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/data_ram_responder.sv
// Single-port word RAM behind a CPU data-port handshake.
// Fixed-latency responder with alignment checking and byte-lane writes.
module data_ram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         wdata_q;
    logic [31:0]         mem_q [DEPTH];

    logic                misaligned;
    logic                commit;
    logic [ADDR_W-1:0]   idx;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_W+2];
    assign idx              = addr_q[ADDR_W+1:2];

    always_comb begin
        case (size_q)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = |addr_q[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        rdata   = '0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                addr_ok = req;
                if (req) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                data_ok = 1'b1;
                err     = misaligned;
                if (!wr_q && !misaligned) rdata = mem_q[idx];
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        // Outputs must drop the moment reset rises, not on the next edge.
        if (rst) begin
            addr_ok = 1'b0;
            data_ok = 1'b0;
            rdata   = '0;
            err     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (addr_ok) begin
                wr_q    <= wr;
                size_q  <= size;
                addr_q  <= addr[ADDR_W+1:0];
                wstrb_q <= wstrb;
                wdata_q <= wdata;
            end
        end
    end

    assign commit = (state_q == RESP) && wr_q && !misaligned && !rst;

    // Array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule
